// File: rtl/program_loader.sv
// Instruction RAM loader and run sequencer for the 8-bit accumulator processor.
// Optional build macro: PROGRAM_LOADER_AUTO_HALT_EN appends a halt word after a short program.
module program_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [11:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic        run,
  input  logic [7:0]  program_counter,
  output logic [11:0] mem_out,
  output logic        cpu_reset,
  output logic        start,
  input  logic        data_ready,
  input  logic [7:0]  accumulator,
  output logic [7:0]  result,
  output logic        result_valid,
  output logic [8:0]  word_count,
  output logic [15:0] run_cycles,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SEAL    = 3'd2,
    S_ARMED   = 3'd3,
    S_CPU_RST = 3'd4,
    S_CPU_ARM = 3'd5,
    S_EXEC    = 3'd6,
    S_DONE    = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  word_count_q, word_count_d;
  logic        rst_cnt_q, rst_cnt_d;
  logic [7:0]  result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic [15:0] run_cycles_q, run_cycles_d;

  logic [11:0] mem [0:255];
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [11:0] mem_wdata;
  logic        accept;
  logic        first_word;

  // Handshake: a host word transfers on any rising clk edge where
  // load_valid && load_ready; load_data/load_last must be stable while load_valid is high.
  assign accept = load_valid && load_ready;

  always_comb begin
    state_d        = state_q;
    word_count_d   = word_count_q;
    rst_cnt_d      = rst_cnt_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    run_cycles_d   = run_cycles_q;
    load_ready     = 1'b0;
    cpu_reset      = 1'b1;
    start          = 1'b0;
    busy           = 1'b1;
    mem_we         = 1'b0;
    mem_waddr      = word_count_q[7:0];
    mem_wdata      = load_data;
    first_word     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy       = 1'b0;
        load_ready = ~word_count_q[8];
        first_word = accept;
      end
      S_LOAD: begin
        load_ready = ~word_count_q[8];
        if (accept) begin
          mem_we       = 1'b1;
          word_count_d = word_count_q + 9'd1;
          if (load_last || (word_count_q == 9'd255)) begin
            state_d = S_SEAL;
          end
        end
      end
      S_SEAL: begin
`ifdef PROGRAM_LOADER_AUTO_HALT_EN
        if (!word_count_q[8]) begin
          mem_we    = 1'b1;
          mem_wdata = 12'hF00;
        end
`endif
        state_d = S_ARMED;
      end
      S_ARMED, S_DONE: begin
        busy       = 1'b0;
        cpu_reset  = (state_q == S_ARMED);
        // run wins over a coincident host word by withholding ready.
        load_ready = ~run;
        if (run) begin
          state_d      = S_CPU_RST;
          rst_cnt_d    = 1'b0;
          run_cycles_d = 16'd0;
        end else begin
          first_word = accept;
        end
      end
      S_CPU_RST: begin
        start        = 1'b1;
        run_cycles_d = 16'd0;
        rst_cnt_d    = 1'b1;
        if (rst_cnt_q) begin
          state_d = S_CPU_ARM;
        end
      end
      S_CPU_ARM: begin
        cpu_reset = 1'b0;
        start     = 1'b1;
        // Hold start until the previous run's halt flag has cleared.
        if (!data_ready) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cpu_reset    = 1'b0;
        run_cycles_d = (run_cycles_q == 16'hFFFF) ? run_cycles_q : run_cycles_q + 16'd1;
        if (data_ready) begin
          result_d       = accumulator;
          result_valid_d = 1'b1;
          state_d        = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A word accepted outside LOAD begins a fresh program at address 0.
    if (first_word) begin
      mem_we         = 1'b1;
      mem_waddr      = 8'd0;
      word_count_d   = 9'd1;
      result_valid_d = 1'b0;
      state_d        = load_last ? S_SEAL : S_LOAD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      word_count_q   <= 9'd0;
      rst_cnt_q      <= 1'b0;
      result_q       <= 8'd0;
      result_valid_q <= 1'b0;
      run_cycles_q   <= 16'd0;
    end else begin
      state_q        <= state_d;
      word_count_q   <= word_count_d;
      rst_cnt_q      <= rst_cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      run_cycles_q   <= run_cycles_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign mem_out      = mem[program_counter];
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign word_count   = word_count_q;
  assign run_cycles   = run_cycles_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a stub processor and scoreboard queues.
module tb_program_loader;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_SEAL    = 3'd2;
  localparam logic [2:0] ST_ARMED   = 3'd3;
  localparam logic [2:0] ST_CPU_RST = 3'd4;
  localparam logic [2:0] ST_CPU_ARM = 3'd5;
  localparam logic [2:0] ST_EXEC    = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic [11:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        run;
  logic [7:0]  program_counter;
  logic [11:0] mem_out;
  logic        cpu_reset;
  logic        start;
  logic        data_ready;
  logic [7:0]  accumulator;
  logic [7:0]  result;
  logic        result_valid;
  logic [8:0]  word_count;
  logic [15:0] run_cycles;
  logic        busy;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_q[$];
  logic [7:0]  res_q[$];
  logic [11:0] prog [0:255];
  logic [11:0] mem2_exp;

  program_loader dut (
    .clk             (clk),
    .reset           (reset),
    .load_valid      (load_valid),
    .load_data       (load_data),
    .load_last       (load_last),
    .load_ready      (load_ready),
    .run             (run),
    .program_counter (program_counter),
    .mem_out         (mem_out),
    .cpu_reset       (cpu_reset),
    .start           (start),
    .data_ready      (data_ready),
    .accumulator     (accumulator),
    .result          (result),
    .result_valid    (result_valid),
    .word_count      (word_count),
    .run_cycles      (run_cycles),
    .busy            (busy),
    .dbg_state       (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Stub core: halt flag drops on the first edge start is seen high, then
  // rises on the 10th edge at which start is seen low again.
  logic       seen_start;
  logic [4:0] stub_cnt;
  initial begin
    data_ready = 1'b1;
    seen_start = 1'b0;
    stub_cnt   = 5'd0;
  end
  always @(posedge clk) begin
    if (start) begin
      data_ready <= 1'b0;
      stub_cnt   <= 5'd0;
      seen_start <= 1'b1;
    end else if (seen_start && !data_ready) begin
      stub_cnt <= stub_cnt + 5'd1;
      if (stub_cnt == 5'd9) begin
        data_ready <= 1'b1;
        seen_start <= 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [11:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic verify_mem(input int n);
    logic [11:0] e;
    for (int pc = 0; pc < n; pc++) begin
      program_counter = pc[7:0];
      #1;
      e = exp_q.pop_front();
      chk($sformatf("mem_out[%0d]", pc), {20'd0, mem_out}, {20'd0, e});
    end
  endtask

  task automatic wait_result(input int budget);
    logic [7:0] e;
    for (int i = 0; i < budget; i++) begin
      if (result_valid) break;
      tick();
    end
    chk("result_valid_timeout", {31'd0, result_valid}, 32'd1);
    e = res_q.pop_front();
    chk("result", {24'd0, result}, {24'd0, e});
    chk("run_cycles", {16'd0, run_cycles}, 32'd11);
    chk("done_state", {29'd0, dbg_state}, {29'd0, ST_DONE});
    chk("done_cpu_reset", {31'd0, cpu_reset}, 32'd0);
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    load_valid      = 1'b0;
    load_data       = 12'd0;
    load_last       = 1'b0;
    run             = 1'b0;
    program_counter = 8'd0;
    accumulator     = 8'h00;
    tick();
    tick();

    // Reset values
    chk("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_word_count", {23'd0, word_count}, 32'd0);
    chk("rst_run_cycles", {16'd0, run_cycles}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();

    // Three-word program
    load_word(12'h105, 1'b0); exp_q.push_back(12'h105);
    chk("load1_word_count", {23'd0, word_count}, 32'd1);
    chk("load1_state", {29'd0, dbg_state}, {29'd0, ST_LOAD});
    load_word(12'h203, 1'b0); exp_q.push_back(12'h203);
    load_word(12'hF00, 1'b1); exp_q.push_back(12'hF00);
    chk("seal_state", {29'd0, dbg_state}, {29'd0, ST_SEAL});
    chk("seal_load_ready", {31'd0, load_ready}, 32'd0);
    chk("seal_word_count", {23'd0, word_count}, 32'd3);
    tick();
    chk("armed_state", {29'd0, dbg_state}, {29'd0, ST_ARMED});
    chk("armed_load_ready", {31'd0, load_ready}, 32'd1);
    chk("armed_busy", {31'd0, busy}, 32'd0);
    verify_mem(3);

    // First run
    tick();
    accumulator = 8'h5A;
    run = 1'b1;
    #1;
    chk("run_load_ready", {31'd0, load_ready}, 32'd0);
    tick();
    run = 1'b0;
    res_q.push_back(8'h5A);
    chk("cpurst1_state", {29'd0, dbg_state}, {29'd0, ST_CPU_RST});
    chk("cpurst1_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("cpurst1_start", {31'd0, start}, 32'd1);
    chk("cpurst1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("cpurst2_state", {29'd0, dbg_state}, {29'd0, ST_CPU_RST});
    chk("cpurst2_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    tick();
    chk("cpuarm_state", {29'd0, dbg_state}, {29'd0, ST_CPU_ARM});
    chk("cpuarm_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("cpuarm_start", {31'd0, start}, 32'd1);
    tick();
    chk("exec_state", {29'd0, dbg_state}, {29'd0, ST_EXEC});
    chk("exec_start", {31'd0, start}, 32'd0);
    wait_result(40);

    // Preload then a short program without halt
    load_word(12'h111, 1'b0);
    chk("newprog_result_valid", {31'd0, result_valid}, 32'd0);
    load_word(12'h222, 1'b0);
    load_word(12'h123, 1'b1);
    tick();
    load_word(12'h1AA, 1'b0);
    load_word(12'h2BB, 1'b1);
    tick();
    chk("short_word_count", {23'd0, word_count}, 32'd2);
`ifdef PROGRAM_LOADER_AUTO_HALT_EN
    mem2_exp = 12'hF00;
`else
    mem2_exp = 12'h123;
`endif
    exp_q.push_back(12'h1AA);
    exp_q.push_back(12'h2BB);
    exp_q.push_back(mem2_exp);
    verify_mem(3);

    // run and load_valid together in ARMED
    tick();
    accumulator = 8'h3C;
    run        = 1'b1;
    load_valid = 1'b1;
    load_data  = 12'h777;
    load_last  = 1'b1;
    #1;
    chk("collide_load_ready", {31'd0, load_ready}, 32'd0);
    tick();
    run        = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    res_q.push_back(8'h3C);
    chk("collide_state", {29'd0, dbg_state}, {29'd0, ST_CPU_RST});
    chk("collide_word_count", {23'd0, word_count}, 32'd2);
    wait_result(40);
    exp_q.push_back(12'h1AA);
    exp_q.push_back(12'h2BB);
    exp_q.push_back(mem2_exp);
    verify_mem(3);

    // Full 256-word program, no load_last
    tick();
    for (int i = 0; i < 256; i++) begin
      prog[i] = 12'($urandom_range(0, 12'hEFF));
      exp_q.push_back(prog[i]);
      load_word(prog[i], 1'b0);
      if (i == 254) begin
        chk("full255_state", {29'd0, dbg_state}, {29'd0, ST_LOAD});
        chk("full255_load_ready", {31'd0, load_ready}, 32'd1);
      end
    end
    chk("full_state", {29'd0, dbg_state}, {29'd0, ST_SEAL});
    chk("full_load_ready", {31'd0, load_ready}, 32'd0);
    chk("full_word_count", {23'd0, word_count}, 32'd256);
    tick();
    chk("full_armed", {29'd0, dbg_state}, {29'd0, ST_ARMED});
    chk("full_word_count_kept", {23'd0, word_count}, 32'd256);
    verify_mem(256);

    // Complete one run, then reset in the middle of the next
    tick();
    accumulator = 8'hA5;
    res_q.push_back(8'hA5);
    start_run();
    wait_result(40);
    start_run();
    for (int i = 0; i < 20; i++) begin
      if (dbg_state == ST_EXEC) break;
      tick();
    end
    chk("midrun_reach_exec", {29'd0, dbg_state}, {29'd0, ST_EXEC});
    chk("midrun_result_valid_before", {31'd0, result_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrun_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("midrun_result_valid", {31'd0, result_valid}, 32'd0);
    chk("midrun_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("midrun_start", {31'd0, start}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("after_reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    for (int i = 0; i < 256; i++) exp_q.push_back(prog[i]);
    verify_mem(256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
